vc_test_src_lfsr: RTL and testbench
===================================

VC_TEST_SRC_LFSR -- requirements
Module: vc_test_src_lfsr

Interface
REQ-001 SHALL have parameter P_MSG_SZ, default 8, message width in bits.
REQ-002 SHALL have parameter P_ENTRIES, default 256, message memory depth (power of two, >=2).
REQ-003 SHALL have parameter P_SEED, default 32'hB1A5_5EED, LFSR reset value.
REQ-004 SHALL have parameter P_DELAY_MASK, default 32'h0000_0007, AND-mask applied to the LFSR to form rand_num.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port load_en  input  1  memory write strobe.
REQ-008 SHALL have port load_addr  input  AW=$clog2(P_ENTRIES)  memory write index.
REQ-009 SHALL have port load_data  input  P_MSG_SZ  memory write data.
REQ-010 SHALL have port num_msgs  input  AW+1  messages to send, sampled on start.
REQ-011 SHALL have port start  input  1  begin sending from entry 0.
REQ-012 SHALL have port out_val  output  1  out_msg valid.
REQ-013 SHALL have port out_rdy  input  1  downstream ready.
REQ-014 SHALL have port out_msg  output  P_MSG_SZ  current message.
REQ-015 SHALL have port rand_num  output  32  masked random delay shared with downstream delay stages.
REQ-016 SHALL have port done  output  1  all num_msgs messages transferred.

Function
REQ-017 SHALL implement FSM states IDLE, SEND, DONE.
REQ-018 SHALL, in IDLE or DONE with start=1: latch num_msgs into cnt_max, clear idx to 0, go to SEND if num_msgs>0, else go to DONE.
REQ-019 SHALL, in SEND, drive out_val=1 and out_msg=mem[idx] combinationally from registered idx (zero-cycle output, no bubble).
REQ-020 SHALL count a transfer only when out_val && out_rdy in the same cycle; idx increments by 1 per transfer.
REQ-021 SHALL, on the transfer with idx==cnt_max-1, go to DONE next cycle; no extra message emitted.
REQ-022 SHALL hold out_msg stable while out_val=1 and out_rdy=0.
REQ-023 SHALL drive out_val=0 in IDLE and DONE; out_msg is don't-care there.
REQ-024 SHALL drive done=1 only in DONE.
REQ-025 SHALL ignore start while in SEND.
REQ-026 SHALL write mem[load_addr]<=load_data on load_en in IDLE or DONE; load_en in SEND is ignored.
REQ-027 SHALL, if num_msgs>P_ENTRIES, clamp cnt_max to P_ENTRIES.
REQ-028 SHALL implement a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (toggle mask 32'h8020_0003), shifting right.
REQ-029 SHALL drive rand_num = lfsr & P_DELAY_MASK, registered (no combinational path from inputs).
REQ-030 SHALL substitute 32'h1 for P_SEED when P_SEED==0 (all-zero lock-up prevention).

Reset
REQ-031 SHALL, when reset_n=0 at a clk edge: state=IDLE, idx=0, cnt_max=0, lfsr=seed (per REQ-030).
REQ-032 SHALL output out_val=0, done=0, rand_num=seed & P_DELAY_MASK in the cycle after reset.
REQ-033 SHALL NOT clear message memory on reset; reset mid-SEND abandons the sequence without emitting further messages.

Configuration
REQ-034 SHALL honour macro VC_TEST_SRC_LFSR_HOLD_EN: defined -> LFSR advances only on cycles with out_val && out_rdy (one random value per message); undefined -> LFSR advances every cycle with reset_n=1.

Verification
REQ-035 SHALL cover: load mem[0..3]=8'h11,22,33,44, num_msgs=4, start, out_rdy=1 -> 11,22,33,44 on four consecutive cycles, done=1 the next cycle.
REQ-036 SHALL cover: same load, out_rdy toggled 1,0,0,1,... -> each message held while stalled, exactly 4 transfers, order preserved.
REQ-037 SHALL cover: num_msgs=0, start -> straight to DONE, out_val never asserted.
REQ-038 SHALL cover: P_SEED=1, P_DELAY_MASK=32'hFFFF_FFFF, macro undefined -> rand_num = 1, 32'h8020_0003, then continued Galois sequence; P_SEED=0 -> identical sequence.
REQ-039 SHALL cover: reset_n=0 after 2 of 4 messages transferred -> out_val=0 next cycle, state IDLE; start afterwards replays from entry 0.
REQ-040 SHALL cover: macro defined, out_rdy=0 for 10 cycles in SEND -> rand_num unchanged across those cycles, changes on the first accepted transfer.

Source files
------------

// File: rtl/vc_test_src_lfsr.sv
// Test source: streams num_msgs preloaded messages over val/rdy and exposes a masked LFSR delay.
// Optional macro VC_TEST_SRC_LFSR_HOLD_EN: LFSR advances only on accepted transfers.
module vc_test_src_lfsr #(
   parameter int unsigned P_MSG_SZ     = 8,
   parameter int unsigned P_ENTRIES    = 256,
   parameter logic [31:0] P_SEED       = 32'hB1A5_5EED,
   parameter logic [31:0] P_DELAY_MASK = 32'h0000_0007,
   localparam int unsigned AW          = $clog2(P_ENTRIES)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                load_en,
   input  logic [AW-1:0]       load_addr,
   input  logic [P_MSG_SZ-1:0] load_data,
   input  logic [AW:0]         num_msgs,
   input  logic                start,
   output logic                out_val,
   input  logic                out_rdy,
   output logic [P_MSG_SZ-1:0] out_msg,
   output logic [31:0]         rand_num,
   output logic                done
);

   localparam logic [31:0] L_SEED    = (P_SEED == 32'h0) ? 32'h1 : P_SEED;
   localparam logic [31:0] L_TAPS    = 32'h8020_0003;
   localparam logic [AW:0] L_ENTRIES = (AW+1)'(P_ENTRIES);

   typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

   state_e              r_state, w_state_nxt;
   logic [AW:0]         r_idx, w_idx_nxt, w_idx_inc;
   logic [AW:0]         r_cnt_max, w_cnt_max_nxt, w_num_clamped;
   logic [P_MSG_SZ-1:0] r_mem [P_ENTRIES];
   logic [31:0]         r_lfsr, w_lfsr_nxt;
   logic                w_xfer, w_lfsr_adv, w_mem_we;

   assign w_xfer        = out_val && out_rdy;
   assign w_idx_inc     = r_idx + 1'b1;
   assign w_num_clamped = (num_msgs > L_ENTRIES) ? L_ENTRIES : num_msgs;

   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_cnt_max_nxt = r_cnt_max;
      out_val       = 1'b0;
      done          = 1'b0;
      w_mem_we      = 1'b0;
      unique case (r_state)
         StIdle, StDone: begin
            done     = (r_state == StDone);
            w_mem_we = load_en;
            if (start) begin
               w_cnt_max_nxt = w_num_clamped;
               w_idx_nxt     = '0;
               w_state_nxt   = (num_msgs != '0) ? StSend : StDone;
            end
         end
         StSend: begin
            out_val = 1'b1;
            if (out_rdy) begin
               w_idx_nxt = w_idx_inc;
               // Last transfer: leave SEND so no extra message appears.
               if (w_idx_inc == r_cnt_max) w_state_nxt = StDone;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= StIdle;
         r_idx     <= '0;
         r_cnt_max <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_cnt_max <= w_cnt_max_nxt;
      end
   end

   // Message store is deliberately not reset.
   always_ff @(posedge clk) begin
      if (reset_n && w_mem_we) r_mem[load_addr] <= load_data;
   end

   assign out_msg = r_mem[r_idx[AW-1:0]];

`ifdef VC_TEST_SRC_LFSR_HOLD_EN
   assign w_lfsr_adv = w_xfer;
`else
   assign w_lfsr_adv = 1'b1;
`endif

   assign w_lfsr_nxt = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? L_TAPS : 32'h0);

   always_ff @(posedge clk) begin
      if (!reset_n)        r_lfsr <= L_SEED;
      else if (w_lfsr_adv) r_lfsr <= w_lfsr_nxt;
   end

   assign rand_num = r_lfsr & P_DELAY_MASK;

endmodule

// File: tb/tb_vc_test_src_lfsr.sv
// Bench for vc_test_src_lfsr: directed scenarios plus random traffic against a behavioural model.
module tb_vc_test_src_lfsr;

   localparam int S_IDLE = 0, S_SEND = 1, S_DONE = 2;

   logic        clk, reset_n, load_en, start, out_rdy;
   logic [7:0]  load_addr, load_data;
   logic [8:0]  num_msgs;
   logic        out_val, done, d2_out_val, d2_done;
   logic [7:0]  out_msg, d2_out_msg;
   logic [31:0] rand_num, d2_rand_num;

   vc_test_src_lfsr #(
      .P_MSG_SZ(8), .P_ENTRIES(256), .P_SEED(32'h0), .P_DELAY_MASK(32'hFFFF_FFFF)
   ) dut (
      .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .num_msgs(num_msgs), .start(start), .out_val(out_val),
      .out_rdy(out_rdy), .out_msg(out_msg), .rand_num(rand_num), .done(done)
   );

   vc_test_src_lfsr dut_dflt (
      .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .num_msgs(num_msgs), .start(start), .out_val(d2_out_val),
      .out_rdy(out_rdy), .out_msg(d2_out_msg), .rand_num(d2_rand_num), .done(d2_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_assert = 0;
   int          n_fail   = 0;
   bit          m_init   = 0;
   int          m_state, m_idx, m_max, m_xfers;
   logic [7:0]  m_mem [256];
   logic [31:0] m_lfsr, m_lfsr2;
   logic [7:0]  q_obs [$];

   // Galois step built from the polynomial exponents x^32+x^22+x^2+x+1.
   function automatic logic [31:0] poly_step(input logic [31:0] s);
      int          exps [4] = '{32, 22, 2, 1};
      logic [31:0] taps = '0;
      foreach (exps[i]) taps[exps[i]-1] = 1'b1;
      return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs at negedge, advance model at posedge, drive window opens #1 later.
   task automatic step();
      bit xfer;
      @(negedge clk);
      if (m_init) begin
         check("out_val", 32'(out_val), 32'(m_state == S_SEND));
         check("done", 32'(done), 32'(m_state == S_DONE));
         check("d2_out_val", 32'(d2_out_val), 32'(m_state == S_SEND));
         if (m_state == S_SEND) check("out_msg", 32'(out_msg), 32'(m_mem[m_idx]));
         check("rand_num", rand_num, m_lfsr);
         check("rand_num_dflt", d2_rand_num, m_lfsr2 & 32'h7);
         if (out_val === 1'b1 && out_rdy === 1'b1) q_obs.push_back(out_msg);
      end
      @(posedge clk);
      xfer = (m_state == S_SEND) && out_rdy;
      if (!reset_n) begin
         m_init = 1; m_state = S_IDLE; m_idx = 0; m_max = 0;
         m_lfsr = 32'h1; m_lfsr2 = 32'hB1A5_5EED;
      end else if (m_init) begin
`ifdef VC_TEST_SRC_LFSR_HOLD_EN
         if (xfer) begin m_lfsr = poly_step(m_lfsr); m_lfsr2 = poly_step(m_lfsr2); end
`else
         m_lfsr = poly_step(m_lfsr); m_lfsr2 = poly_step(m_lfsr2);
`endif
         if (m_state == S_SEND) begin
            if (xfer) begin
               m_xfers++;
               m_idx++;
               if (m_idx == m_max) m_state = S_DONE;
            end
         end else begin
            if (load_en) m_mem[load_addr] = load_data;
            if (start) begin
               m_max   = (int'(num_msgs) > 256) ? 256 : int'(num_msgs);
               m_idx   = 0;
               m_state = (m_max > 0) ? S_SEND : S_DONE;
            end
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      load_en = 0; start = 0; out_rdy = 0; load_addr = '0; load_data = '0; num_msgs = '0;
   endtask

   task automatic check_seq(input string tag);
      logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      check({tag, "_count"}, 32'(q_obs.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         check(tag, (i < q_obs.size()) ? 32'(q_obs[i]) : 32'hDEAD, 32'(exp[i]));
      q_obs.delete();
   endtask

   task automatic load_base();
      logic [7:0] v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         load_en = 1; load_addr = 8'(i); load_data = v[i]; step();
      end
      load_en = 0;
   endtask

   initial begin
      idle_inputs();
      reset_n = 0;
      #1;
      step(); step();
      reset_n = 1;
      // Seed 0 is replaced by 1; first advance gives the toggle mask.
      check("seed0_subst", rand_num, 32'h1);
      check("seed_dflt", d2_rand_num, 32'h5);
      check("rst_out_val", 32'(out_val), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      step();
`ifdef VC_TEST_SRC_LFSR_HOLD_EN
      check("lfsr_first", rand_num, 32'h1);
`else
      check("lfsr_first", rand_num, 32'h8020_0003);
`endif

      // Fill all entries randomly, then the known prefix.
      for (int i = 0; i < 256; i++) begin
         load_en = 1; load_addr = 8'(i); load_data = 8'($urandom); step();
      end
      load_base();
      q_obs.delete();

      // Full-rate burst.
      num_msgs = 9'd4; start = 1; step(); start = 0;
      out_rdy = 1;
      for (int i = 0; i < 6; i++) step();
      check_seq("burst");

      // Stalled delivery with rdy pattern 1,0,0,1.
      num_msgs = 9'd4; start = 1; out_rdy = 0; step(); start = 0;
      for (int i = 0; i < 16; i++) begin
         out_rdy = (i % 4 == 0) || (i % 4 == 3); step();
      end
      check_seq("stall");

`ifdef VC_TEST_SRC_LFSR_HOLD_EN
      // Long stall: LFSR must not move until a transfer is accepted.
      num_msgs = 9'd4; start = 1; out_rdy = 0; step(); start = 0;
      for (int i = 0; i < 10; i++) step();
      out_rdy = 1;
      for (int i = 0; i < 5; i++) step();
      check_seq("hold");
`endif

      // Zero-length request goes straight to DONE.
      num_msgs = 9'd0; start = 1; out_rdy = 1; step(); start = 0;
      check("zero_done", 32'(done), 32'h1);
      for (int i = 0; i < 3; i++) step();
      check("zero_noxfer", 32'(q_obs.size()), 32'h0);

      // Reset after two transfers abandons the sequence; restart replays from entry 0.
      num_msgs = 9'd4; start = 1; out_rdy = 1; step(); start = 0;
      step(); step();
      check("pre_rst_xfers", 32'(q_obs.size()), 32'd2);
      reset_n = 0; step(); reset_n = 1;
      check("mid_rst_val", 32'(out_val), 32'h0);
      step(); step();
      q_obs.delete();
      num_msgs = 9'd4; start = 1; step(); start = 0;
      for (int i = 0; i < 6; i++) step();
      check_seq("replay");

      // Oversized request clamps to the memory depth.
      m_xfers = 0;
      num_msgs = 9'd300; start = 1; step(); start = 0;
      for (int i = 0; i < 262; i++) step();
      check("clamp_xfers", 32'(m_xfers), 32'd256);
      check("clamp_dut_xfers", 32'(q_obs.size()), 32'd256);
      check("clamp_done", 32'(done), 32'h1);
      q_obs.delete();

      // Random traffic, including start/load during SEND.
      for (int i = 0; i < 400; i++) begin
         load_en   = ($urandom % 4) == 0;
         load_addr = 8'($urandom_range(0, 31));
         load_data = 8'($urandom);
         start     = ($urandom % 6) == 0;
         num_msgs  = 9'($urandom_range(0, 24));
         out_rdy   = $urandom % 2;
         step();
      end
      idle_inputs();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
